rgb_pwm_array: RTL and testbench

//  Parametrised multi-LED RGB PWM driver; successor to the single-LED switchPanel driver.

---
 rtl/rgb_pwm_array.sv | 202 ++++++++++++++++++++
 tb/tb_rgb_pwm_array.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_array.sv
// rgb_pwm_array: multi-LED RGB565 PWM driver with static, blink, breathe and off modes.
// Colour and mode requests are staged and only take effect at a PWM frame boundary,
// so a duty cycle never changes partway through a frame.
module rgb_pwm_array #(
  parameter int NUM_LEDS       = 2,
  parameter int PRESCALE       = 1,
  parameter int BLINK_FRAMES   = 32,
  parameter int BREATHE_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*NUM_LEDS-1:0] color_in,
  input  logic [1:0]            mode,
  input  logic                  load,
  output logic [NUM_LEDS-1:0]   rLED,
  output logic [NUM_LEDS-1:0]   gLED,
  output logic [NUM_LEDS-1:0]   bLED,
  output logic                  frame_start
);

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_t;

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FMAX = (BLINK_FRAMES > BREATHE_FRAMES) ? BLINK_FRAMES : BREATHE_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  logic [PW-1:0]          pre_cnt;
  logic                   tick;
  logic [5:0]             pwm_cnt;
  logic                   wrap;
  logic                   pending;
  logic [16*NUM_LEDS-1:0] stage_color;
  logic [1:0]             stage_mode;
  logic [16*NUM_LEDS-1:0] shadow_color;
  mode_t                  state;
  mode_t                  next_state;
  logic                   mode_entry;
  logic [FW-1:0]          frame_cnt;
  logic [5:0]             bright;
  logic                   dir_up;
  logic                   blink_on;
  logic [NUM_LEDS-1:0]    r_next;
  logic [NUM_LEDS-1:0]    g_next;
  logic [NUM_LEDS-1:0]    b_next;

  // Scale a raw channel duty by the active mode's brightness rule.
  function automatic logic [5:0] eff_duty(input logic [5:0] d, input mode_t st,
                                          input logic [5:0] br, input logic on);
    logic [11:0] prod;
    logic [5:0]  res;
    prod = {6'd0, d} * {6'd0, br};
    case (st)
      MODE_STATIC:  res = d;
      MODE_BLINK:   res = on ? d : 6'd0;
      MODE_BREATHE: res = prod[11:6];
      default:      res = 6'd0;
    endcase
    return res;
  endfunction

  assign tick        = (pre_cnt == PW'(PRESCALE - 1));
  assign wrap        = tick && (pwm_cnt == 6'd63);
  assign frame_start = wrap;

  // Prescaler and 6-bit PWM counter form the frame timebase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      pwm_cnt <= 6'd0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 6'd1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Staging register collects the latest request; it moves to the shadow copy only at a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= 1'b0;
      stage_color  <= '0;
      stage_mode   <= 2'b00;
      shadow_color <= '0;
    end else begin
      if (wrap && pending) begin
        shadow_color <= stage_color;
      end
      if (load) begin
        pending     <= 1'b1;
        stage_color <= color_in;
        stage_mode  <= mode;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Mode state register; the state is the shadow copy of the requested mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MODE_STATIC;
    end else begin
      state <= next_state;
    end
  end

  // Next mode comes from the staged request, but only at a frame wrap.
  always_comb begin
    next_state = state;
    mode_entry = 1'b0;
    if (wrap && pending) begin
      next_state = mode_t'(stage_mode);
      mode_entry = (stage_mode != state);
    end
  end

  // Per-frame sequencing of blink phase and breathe brightness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      bright    <= 6'd0;
      dir_up    <= 1'b1;
      blink_on  <= 1'b1;
    end else if (wrap) begin
      if (mode_entry) begin
        frame_cnt <= '0;
        blink_on  <= 1'b1;
        if (next_state == MODE_BREATHE) begin
          bright <= 6'd0;
          dir_up <= 1'b1;
        end
      end else begin
        case (state)
          MODE_BLINK: begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
              frame_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          MODE_BREATHE: begin
            if (frame_cnt == FW'(BREATHE_FRAMES - 1)) begin
              frame_cnt <= '0;
              if (dir_up) begin
                if (bright == 6'd63) begin
                  dir_up <= 1'b0;
                  bright <= 6'd62;
                end else begin
                  bright <= bright + 6'd1;
                end
              end else begin
                if (bright == 6'd0) begin
                  dir_up <= 1'b1;
                  bright <= 6'd1;
                end else begin
                  bright <= bright - 6'd1;
                end
              end
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          default: frame_cnt <= '0;
        endcase
      end
    end
  end

  // Per-LED compare of the PWM counter against each channel's effective duty.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [4:0] red;
    logic [5:0] grn;
    logic [4:0] blu;
    assign red = shadow_color[16*i+11 +: 5];
    assign grn = shadow_color[16*i+5 +: 6];
    assign blu = shadow_color[16*i +: 5];
    assign r_next[i] = pwm_cnt < eff_duty({red, red[4]}, state, bright, blink_on);
    assign g_next[i] = pwm_cnt < eff_duty(grn, state, bright, blink_on);
    assign b_next[i] = pwm_cnt < eff_duty({blu, blu[4]}, state, bright, blink_on);
  end

  // Register the compare results so the pins are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rLED <= '0;
      gLED <= '0;
      bLED <= '0;
    end else begin
      rLED <= r_next;
      gLED <= g_next;
      bLED <= b_next;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_array.sv
// tb_rgb_pwm_array: directed bench for rgb_pwm_array with two LEDs, no prescaling,
// two-frame blink half-period and one-frame breathe step.
module tb_rgb_pwm_array;

  localparam int NUM_LEDS = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [16*NUM_LEDS-1:0] color_in = '0;
  logic [1:0]             mode = 2'b00;
  logic                   load = 1'b0;
  logic [NUM_LEDS-1:0]    rLED;
  logic [NUM_LEDS-1:0]    gLED;
  logic [NUM_LEDS-1:0]    bLED;
  logic                   frame_start;

  int vectors = 0;
  int miscompares = 0;
  int dutyR [128][NUM_LEDS];
  int dutyG [128][NUM_LEDS];
  int dutyB [128][NUM_LEDS];
  logic [NUM_LEDS-1:0] seenR, seenG, seenB;
  int waitCycles;

  rgb_pwm_array #(
    .NUM_LEDS(NUM_LEDS), .PRESCALE(1), .BLINK_FRAMES(2), .BREATHE_FRAMES(1)
  ) dut (
    .clk(clk), .rst(rst), .color_in(color_in), .mode(mode), .load(load),
    .rLED(rLED), .gLED(gLED), .bLED(bLED), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present colours and mode with a one-cycle load strobe; call at a negedge.
  task automatic applyStimulus(input logic [15:0] c0, input logic [15:0] c1, input logic [1:0] m);
    color_in = {c1, c0};
    mode = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) for the frame_start pulse, recording any output activity seen meanwhile.
  task automatic waitWrap(input string tag);
    int n;
    int found;
    n = 0;
    found = 0;
    seenR = '0;
    seenG = '0;
    seenB = '0;
    while (found == 0 && n < 200) begin
      @(negedge clk);
      n++;
      seenR |= rLED;
      seenG |= gLED;
      seenB |= bLED;
      if (frame_start) found = 1;
    end
    waitCycles = n;
    checkOutput(tag, found, 1);
  endtask

  // Count high samples per channel over consecutive frames; starts on the negedge after a wrap edge.
  task automatic measureFrames(input int nf);
    for (int f = 0; f < nf; f++) begin
      for (int l = 0; l < NUM_LEDS; l++) begin
        dutyR[f][l] = 0;
        dutyG[f][l] = 0;
        dutyB[f][l] = 0;
      end
      repeat (64) begin
        @(negedge clk);
        for (int l = 0; l < NUM_LEDS; l++) begin
          dutyR[f][l] += int'(rLED[l]);
          dutyG[f][l] += int'(gLED[l]);
          dutyB[f][l] += int'(bLED[l]);
        end
      end
    end
  endtask

  // Expected breathe duty for a full-scale channel in frame f after entry.
  function automatic int breatheDuty(input int f);
    int p;
    int b;
    p = f % 126;
    b = (p <= 63) ? p : 126 - p;
    return (63 * b) >> 6;
  endfunction

  initial begin
    // Reset held with all-ones colour input
    color_in = '1;
    repeat (4) @(negedge clk);
    checkOutput("reset_r", int'(rLED), 0);
    checkOutput("reset_g", int'(gLED), 0);
    checkOutput("reset_b", int'(bLED), 0);
    checkOutput("reset_fs", int'(frame_start), 0);
    rst = 1'b1;
    waitWrap("wrap_after_reset");
    checkOutput("first_wrap_cycles", waitCycles, 63);
    checkOutput("post_reset_seen", int'({seenR, seenG, seenB}), 0);
    @(negedge clk);
    measureFrames(1);
    checkOutput("post_reset_r", dutyR[0][0] + dutyR[0][1], 0);
    checkOutput("post_reset_g", dutyG[0][0] + dutyG[0][1], 0);
    checkOutput("post_reset_b", dutyB[0][0] + dutyB[0][1], 0);

    // Static red on LED0
    applyStimulus(16'hF800, 16'h0000, 2'b00);
    waitWrap("wrap_static");
    checkOutput("static_no_early_r", int'(seenR), 0);
    @(negedge clk);
    measureFrames(1);
    checkOutput("static_r0", dutyR[0][0], 63);
    checkOutput("static_g0", dutyG[0][0], 0);
    checkOutput("static_b0", dutyB[0][0], 0);
    checkOutput("static_r1", dutyR[0][1], 0);

    // Mid-frame load at pwm_cnt 10 waits for the wrap
    repeat (10) @(negedge clk);
    applyStimulus(16'h07E0, 16'h0000, 2'b00);
    waitWrap("wrap_shadow");
    checkOutput("shadow_no_early_g", int'(seenG), 0);
    checkOutput("shadow_old_r_kept", int'(seenR[0]), 1);
    @(negedge clk);
    measureFrames(1);
    checkOutput("shadow_g0", dutyG[0][0], 63);
    checkOutput("shadow_r0", dutyR[0][0], 0);

    // Load coincident with wrap applies one frame later
    waitWrap("wrap_coincident");
    applyStimulus(16'h001F, 16'h0000, 2'b00);
    measureFrames(2);
    checkOutput("coinc_f0_g0", dutyG[0][0], 63);
    checkOutput("coinc_f0_b0", dutyB[0][0], 0);
    checkOutput("coinc_f1_g0", dutyG[1][0], 0);
    checkOutput("coinc_f1_b0", dutyB[1][0], 63);

    // Blink on LED1: two frames lit, two frames dark
    applyStimulus(16'h0000, 16'hFFFF, 2'b01);
    waitWrap("wrap_blink");
    @(negedge clk);
    measureFrames(6);
    checkOutput("blink_f0_r1", dutyR[0][1], 63);
    checkOutput("blink_f1_g1", dutyG[1][1], 63);
    checkOutput("blink_f2_r1", dutyR[2][1], 0);
    checkOutput("blink_f3_b1", dutyB[3][1], 0);
    checkOutput("blink_f4_b1", dutyB[4][1], 63);
    checkOutput("blink_f5_r1", dutyR[5][1], 63);
    checkOutput("blink_f0_r0", dutyR[0][0], 0);

    // Breathe ramp up to 63 and back down
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b10);
    waitWrap("wrap_breathe");
    @(negedge clk);
    measureFrames(128);
    for (int f = 0; f < 128; f++) begin
      checkOutput($sformatf("breathe_f%0d_r0", f), dutyR[f][0], breatheDuty(f));
    end
    checkOutput("breathe_bright32_g1", dutyG[32][1], 31);
    checkOutput("breathe_peak_b1", dutyB[63][1], 62);
    checkOutput("breathe_floor_g0", dutyG[126][0], 0);

    // Two loads in one frame, the later (off) wins
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b00);
    repeat (3) @(negedge clk);
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b11);
    waitWrap("wrap_off");
    @(negedge clk);
    measureFrames(1);
    checkOutput("off_r", dutyR[0][0] + dutyR[0][1], 0);
    checkOutput("off_g", dutyG[0][0] + dutyG[0][1], 0);
    checkOutput("off_b", dutyB[0][0] + dutyB[0][1], 0);

    // Asynchronous reset mid-frame
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b00);
    waitWrap("wrap_prereset");
    repeat (5) @(negedge clk);
    checkOutput("prereset_r", int'(rLED), 3);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_r", int'(rLED), 0);
    checkOutput("async_reset_g", int'(gLED), 0);
    checkOutput("async_reset_b", int'(bLED), 0);
    @(negedge clk);
    rst = 1'b1;
    waitWrap("wrap_after_midreset");
    checkOutput("midreset_wrap_cycles", waitCycles, 63);
    @(negedge clk);
    measureFrames(1);
    checkOutput("midreset_r", dutyR[0][0] + dutyR[0][1], 0);
    checkOutput("midreset_g", dutyG[0][0] + dutyG[0][1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
